dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_array.sv | 44 ++++
 rtl/dcache.sv | 170 +++++++++++++++++
 tb/tb_dcache.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    BUS_RD = 3'd2,
    BUS_WR = 3'd3,
    RESP   = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam int WORD_OFFSET     = 3;
  localparam int BUS_TIMEOUT_DEF = 255;

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid bits with async clear, tag/data arrays with no reset.
// Combinational read and synchronous write share one line index.
module dcache_array #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 57
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [63:0]      o_data,
  input  logic             i_wr_en,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [63:0]      i_wr_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [63:0]          r_data [NUM_LINES];

  // valid bits: cleared by reset, set by any line write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  // tag and data payload
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_idx]  <= i_wr_tag;
      r_data[i_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a bus timeout.
// Optional hit/miss statistics counters when DCACHE_STATS_EN is defined.
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES   = 16,
  parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_enable,
  input  logic        cache_wr_en,
  input  logic [63:0] cache_rd_addr,
  input  logic [63:0] cache_wr_addr,
  input  logic [63:0] cache_wr_value,
  output logic [63:0] cache_data,
  output logic        cache_operation_complete,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_error
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 64 - WORD_OFFSET - IDX_W;
  localparam int TMO_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT - 1);

  state_t                r_state;
  logic                  r_we;
  logic [63-WORD_OFFSET:0] r_addr;
  logic [63:0]           r_wval;
  logic [63:0]           r_result;
  logic [TMO_W-1:0]      r_tmo;

  logic                  w_valid;
  logic [TAG_W-1:0]      w_tag;
  logic [63:0]           w_data;
  logic                  w_hit;
  logic                  w_wr_en;
  logic [63:0]           w_wr_data;

  // Line writes: store hit during lookup, or a fill on read ack.
  assign w_hit     = w_valid && (w_tag == r_addr[63-WORD_OFFSET:IDX_W]);
  assign w_wr_en   = ((r_state == LOOKUP) && r_we && w_hit) ||
                     ((r_state == BUS_RD) && bus_ack);
  assign w_wr_data = r_we ? r_wval : bus_rdata;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (r_addr[IDX_W-1:0]),
    .o_valid   (w_valid),
    .o_tag     (w_tag),
    .o_data    (w_data),
    .i_wr_en   (w_wr_en),
    .i_wr_tag  (r_addr[63-WORD_OFFSET:IDX_W]),
    .i_wr_data (w_wr_data)
  );

  // request sequencing, bus handshake and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state                  <= IDLE;
      r_we                     <= 1'b0;
      r_addr                   <= '0;
      r_wval                   <= 64'd0;
      r_result                 <= 64'd0;
      r_tmo                    <= '0;
      cache_data               <= 64'd0;
      cache_operation_complete <= 1'b0;
      bus_req                  <= 1'b0;
      bus_we                   <= 1'b0;
      bus_addr                 <= 64'd0;
      bus_wdata                <= 64'd0;
      bus_error                <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cache_enable) begin
            r_we    <= cache_wr_en;
            r_addr  <= cache_wr_en ? cache_wr_addr[63:WORD_OFFSET]
                                   : cache_rd_addr[63:WORD_OFFSET];
            r_wval  <= cache_wr_value;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_tmo <= '0;
          if (r_we) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= {r_addr, 3'b000};
            bus_wdata <= r_wval;
            r_result  <= 64'd0;
            r_state   <= BUS_WR;
          end else if (w_hit) begin
            r_result <= w_data;
            r_state  <= RESP;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= {r_addr, 3'b000};
            bus_wdata <= 64'd0;
            r_state   <= BUS_RD;
          end
        end
        BUS_RD, BUS_WR: begin
          // an ack on the final allowed cycle still wins over the timeout
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (r_state == BUS_RD) begin
              r_result <= bus_rdata;
            end
            r_state <= RESP;
          end else if (r_tmo == TMO_LAST) begin
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            r_result  <= {64{1'b1}};
            r_state   <= RESP;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        RESP: begin
          cache_operation_complete <= 1'b1;
          cache_data               <= r_result;
          r_state                  <= HOLD;
        end
        HOLD: begin
          cache_operation_complete <= 1'b0;
          cache_data               <= 64'd0;
          r_state                  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // saturating load hit/miss counters, updated once per load lookup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if ((r_state == LOOKUP) && !r_we) begin
      if (w_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: vector table plus scoreboard of expected load results.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_enable;
  logic        cache_wr_en;
  logic [63:0] cache_rd_addr;
  logic [63:0] cache_wr_addr;
  logic [63:0] cache_wr_value;
  logic [63:0] cache_data;
  logic        cache_operation_complete;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        bus_ack;
  logic        bus_error;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  int          m_hits   = 0;
  int          m_misses = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wval;
    logic [63:0] rdata;
    int          dly;       // ack after this many bus_req cycles, 0 = never
    logic        exp_bus;
    logic [63:0] exp_baddr;
    logic [63:0] exp_data;
    logic        drop;      // release cache_enable right after accept
    logic        noise;     // hold bus_ack high while no bus request is open
  } vec_t;

  vec_t vecs[17];

  dcache dut (
    .clk                      (clk),
    .rst                      (rst),
    .cache_enable             (cache_enable),
    .cache_wr_en              (cache_wr_en),
    .cache_rd_addr            (cache_rd_addr),
    .cache_wr_addr            (cache_wr_addr),
    .cache_wr_value           (cache_wr_value),
    .cache_data               (cache_data),
    .cache_operation_complete (cache_operation_complete),
    .bus_req                  (bus_req),
    .bus_we                   (bus_we),
    .bus_addr                 (bus_addr),
    .bus_wdata                (bus_wdata),
    .bus_rdata                (bus_rdata),
    .bus_ack                  (bus_ack),
    .bus_error                (bus_error)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count                (hit_count),
    .miss_count               (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wval,
                              input logic [63:0] rdata, input int dly, input logic exp_bus,
                              input logic [63:0] exp_baddr, input logic [63:0] exp_data,
                              input logic drop, input logic noise);
    vec_t v;
    v.we = we; v.addr = addr; v.wval = wval; v.rdata = rdata; v.dly = dly;
    v.exp_bus = exp_bus; v.exp_baddr = exp_baddr; v.exp_data = exp_data;
    v.drop = drop; v.noise = noise;
    return v;
  endfunction

  // Drive one request from IDLE, act as backing memory, and check the completion.
  task automatic run_req(input vec_t v, input string tag);
    int   n      = 0;
    int   reqc   = 0;
    bit   done   = 1'b0;
    bit   seen   = 1'b0;
    bit   stable = 1'b1;
    bit   ack_prev = 1'b0;
    logic [63:0] exp;
    sb.push_back(v.exp_data);
`ifdef DCACHE_STATS_EN
    if (!v.we) begin
      if (v.exp_bus) m_misses++; else m_hits++;
    end
`endif
    cache_wr_en    = v.we;
    cache_rd_addr  = v.we ? 64'hFFFF_0000_0000_0000 : v.addr;
    cache_wr_addr  = v.we ? v.addr : 64'hFFFF_0000_0000_0000;
    cache_wr_value = v.wval;
    cache_enable   = 1'b1;
    while (!done && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (v.drop && n == 1) cache_enable = 1'b0;
      if (ack_prev) chk({tag, ".req_drop"}, {63'd0, bus_req}, 64'd0);
      bus_ack  = 1'b0;
      ack_prev = 1'b0;
      if (bus_req) begin
        seen = 1'b1;
        reqc++;
        if (bus_addr !== v.exp_baddr || bus_we !== v.we || (v.we && bus_wdata !== v.wval))
          stable = 1'b0;
        if (v.dly != 0 && reqc == v.dly) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdata;
          ack_prev  = 1'b1;
        end
      end else if (v.noise) begin
        bus_ack   = 1'b1;
        bus_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
      end
      if (cache_operation_complete) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
          exp = sb.pop_front();
          chk({tag, ".data"}, cache_data, exp);
        end
      end
    end
    bus_ack = 1'b0;
    if (!done) begin
      chk({tag, ".complete_timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    chk({tag, ".bus_used"}, {63'd0, seen}, {63'd0, v.exp_bus});
    if (seen) chk({tag, ".bus_fields"}, {63'd0, stable}, 64'd1);
    if (!v.we && !v.exp_bus) chk({tag, ".hit_latency"}, 64'(n - 1), 64'd2);
    if (v.exp_bus && v.dly == 0) chk({tag, ".timeout_cycles"}, 64'(reqc), 64'd255);
    cache_enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".pulse_one_cycle"}, {63'd0, cache_operation_complete}, 64'd0);
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 64'h1000, 64'h0, 64'hDEADBEEF, 3, 1'b1, 64'h1000, 64'hDEADBEEF, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 64'h1000, 64'h0, 64'h0, 0, 1'b0, 64'h0, 64'hDEADBEEF, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 64'h1000, 64'h55, 64'h0, 2, 1'b1, 64'h1000, 64'h0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 64'h1004, 64'h0, 64'h0, 0, 1'b0, 64'h0, 64'h55, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 64'h2000, 64'h77, 64'h0, 1, 1'b1, 64'h2000, 64'h0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 64'h2000, 64'h0, 64'h1234, 2, 1'b1, 64'h2000, 64'h1234, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 64'h1080, 64'h0, 64'hAAAA, 1, 1'b1, 64'h1080, 64'hAAAA, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 64'h1000, 64'h0, 64'hBBBB, 4, 1'b1, 64'h1000, 64'hBBBB, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 64'h1000, 64'h0, 64'h0, 0, 1'b0, 64'h0, 64'hBBBB, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 64'h300F, 64'h0, 64'h3333, 1, 1'b1, 64'h3008, 64'h3333, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 64'h300A, 64'h0, 64'h0, 0, 1'b0, 64'h0, 64'h3333, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 64'h3008, 64'h99, 64'h0, 1, 1'b1, 64'h3008, 64'h0, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 64'h300C, 64'h0, 64'h0, 0, 1'b0, 64'h0, 64'h99, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0123, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0123, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 64'h78, 64'h0, 64'h7878, 2, 1'b1, 64'h78, 64'h7878, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h4444, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4444, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 0, 1'b0, 64'h0, 64'h4444, 1'b0, 1'b0);

    rst = 1'b1; cache_enable = 1'b0; cache_wr_en = 1'b0;
    cache_rd_addr = 64'd0; cache_wr_addr = 64'd0; cache_wr_value = 64'd0;
    bus_rdata = 64'd0; bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.complete", {63'd0, cache_operation_complete}, 64'd0);
    chk("reset.data", cache_data, 64'd0);
    chk("reset.bus_req", {63'd0, bus_req}, 64'd0);
    chk("reset.bus_addr", bus_addr, 64'd0);
    chk("reset.bus_error", {63'd0, bus_error}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // bus never acks: timeout, all-ones result, line 0 must keep 0x1000
    run_req(mk(1'b0, 64'h4000, 64'h0, 64'h0, 0, 1'b1, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0), "timeout");
    chk("timeout.bus_error", {63'd0, bus_error}, 64'd1);
    run_req(mk(1'b0, 64'h1000, 64'h0, 64'h0, 0, 1'b0, 64'h0, 64'hBBBB, 1'b0, 1'b0), "after_timeout");
    chk("bus_error.sticky", {63'd0, bus_error}, 64'd1);

    // reset in the middle of a bus read
    cache_wr_en = 1'b0; cache_rd_addr = 64'h5000; cache_enable = 1'b1;
    for (int k = 0; k < 10 && !bus_req; k++) begin
      @(posedge clk); #1;
    end
    chk("midrst.setup_req", {63'd0, bus_req}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst.bus_req", {63'd0, bus_req}, 64'd0);
    chk("midrst.bus_addr", bus_addr, 64'd0);
    chk("midrst.bus_error", {63'd0, bus_error}, 64'd0);
    chk("midrst.complete", {63'd0, cache_operation_complete}, 64'd0);
    cache_enable = 1'b0;
`ifdef DCACHE_STATS_EN
    m_hits = 0; m_misses = 0;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_req(mk(1'b0, 64'h1000, 64'h0, 64'hCCCC, 2, 1'b1, 64'h1000, 64'hCCCC, 1'b0, 1'b0), "after_rst");

`ifdef DCACHE_STATS_EN
    chk("stats.hits", {32'd0, hit_count}, 64'(m_hits));
    chk("stats.misses", {32'd0, miss_count}, 64'(m_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
